// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch stage between the PC register and decode.
// It issues one instruction-memory read at a time (req/gnt/rvalid), steps the
// PC register with a one-cycle pc_advance strobe, and buffers the returned
// words together with their PCs in a DEPTH-entry FIFO. A flush discards
// everything that is queued or in flight.
//
// Handshakes:
//   imem:   a request is accepted in a cycle with imem_req && imem_gnt.
//           imem_addr is held stable while imem_req is high. Exactly one
//           response (imem_rvalid) follows each accepted request.
//           Before a grant, the request may be withdrawn on flush.
//   decode: the head entry is consumed in a cycle with
//           instr_valid && decode_ready (and no flush).
module ifetch_queue #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_advance,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              decode_ready,
  output logic [1:0]        dbg_state_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] epc_q  [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push, pop;

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = addr_q;
  assign instr_valid = (count_q != '0);
  assign instr       = data_q[rd_ptr_q];
  assign instr_pc    = epc_q[rd_ptr_q];
  assign dbg_state_o = state_q;

  // Flush wins over a same-cycle pop; the whole FIFO is dropped instead.
  assign pop = instr_valid && decode_ready && !flush;

  // Fetch FSM next state, PC strobe and FIFO push decision.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pc_advance = 1'b0;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Only issue when a slot is guaranteed for the response.
        if (!flush && (count_q < CNT_W'(DEPTH))) begin
          addr_d  = pc_in;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_gnt && !flush) begin
          pc_advance = 1'b1;
          state_d    = S_WAIT;
        end else if (imem_gnt) begin
          // Granted but already stale: swallow the response.
          state_d = S_DROP;
        end else if (flush) begin
          // Nothing committed yet, so the request can simply be withdrawn.
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          push    = !flush;
          state_d = S_IDLE;
        end else if (flush) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and captured fetch address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // FIFO storage, pointers and occupancy; flush empties it in one edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        epc_q[i]  <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= imem_rdata;
        epc_q[wr_ptr_q]  <= addr_q;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
